// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: one-gate entry/exit arbiter for a 4-spot lot with occupancy tracking
//   clk              system clock, rising edge
//   reset            asynchronous active-high reset
//   entry_req        car waiting at entry (level)
//   exit_req         car waiting at exit (level)
//   exit_pos         spot the exiting car leaves, valid with exit_req
//   car_passed       gate sensor, car cleared the barrier
//   gate_open        barrier open command (OPEN_ENTRY/OPEN_EXIT)
//   entry_grant      pulse in first cycle of an entry opening
//   exit_grant       pulse in first cycle of an exit opening
//   assigned_pos     spot assigned to the current/last entering car
//   parking_spots    occupancy bitmap, bit i set = spot i occupied
//   capacity         free spot count 0..4
//   full_led         capacity == 0
//   err_invalid_exit pulse while in IDLE with an exit request for an empty spot
//   timeout          pulse in the last open cycle when car_passed never came
module parking_gate_arbiter #(
    parameter int unsigned DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_pos,
    input  logic       car_passed,
    output logic       gate_open,
    output logic       entry_grant,
    output logic       exit_grant,
    output logic [1:0] assigned_pos,
    output logic [3:0] parking_spots,
    output logic [2:0] capacity,
    output logic       full_led,
    output logic       err_invalid_exit,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, OPEN_ENTRY, OPEN_EXIT, CLOSING} state_t;
    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [3:0] spots_d;
    logic [2:0] cap_d;
    logic [1:0] apos_d, xpos, xpos_d, free_pos;
    logic       rr_exit, rr_exit_d;
    logic       idle, open, entry_ok, exit_ok, grant_entry, grant_exit;
    assign idle        = state == IDLE;
    assign open        = state == OPEN_ENTRY || state == OPEN_EXIT;
    assign gate_open   = open;
    assign full_led    = capacity == 3'd0;
    assign entry_ok    = entry_req & ~full_led;
    assign exit_ok     = exit_req & parking_spots[exit_pos];
    // rr_exit set means exit wins a tie; it always points away from the last grant
    assign grant_exit  = idle & exit_ok & (~entry_ok | rr_exit);
    assign grant_entry = idle & entry_ok & ~grant_exit;
    assign err_invalid_exit = idle & exit_req & ~parking_spots[exit_pos];
    assign timeout     = open & ~car_passed & (cnt == 8'd1);
    assign free_pos    = ~parking_spots[0] ? 2'd0 : ~parking_spots[1] ? 2'd1 :
                         ~parking_spots[2] ? 2'd2 : 2'd3;
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        spots_d   = parking_spots;
        apos_d    = assigned_pos;
        xpos_d    = xpos;
        rr_exit_d = rr_exit;
        case (state)
            IDLE: begin
                if (grant_exit) begin
                    state_d   = OPEN_EXIT;
                    cnt_d     = 8'(DOOR_CYCLES);
                    xpos_d    = exit_pos;
                    rr_exit_d = 1'b0;
                end else if (grant_entry) begin
                    state_d   = OPEN_ENTRY;
                    cnt_d     = 8'(DOOR_CYCLES);
                    apos_d    = free_pos;
                    rr_exit_d = 1'b1;
                end
            end
            OPEN_ENTRY, OPEN_EXIT: begin
                // commit has priority over the window expiring in the same cycle
                if (car_passed) begin
                    if (state == OPEN_ENTRY) spots_d[assigned_pos] = 1'b1;
                    else spots_d[xpos] = 1'b0;
                    state_d = CLOSING;
                end else if (cnt == 8'd1) begin
                    state_d = CLOSING;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        cap_d = 3'd4 - 3'($countones(spots_d));
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            parking_spots <= 4'd0;
            capacity      <= 3'd4;
            assigned_pos  <= 2'd0;
            xpos          <= 2'd0;
            rr_exit       <= 1'b1;
            entry_grant   <= 1'b0;
            exit_grant    <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            parking_spots <= spots_d;
            capacity      <= cap_d;
            assigned_pos  <= apos_d;
            xpos          <= xpos_d;
            rr_exit       <= rr_exit_d;
            entry_grant   <= grant_entry;
            exit_grant    <= grant_exit;
        end
    end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: randomized check of parking_gate_arbiter against a transaction-level model
module tb_parking_gate_arbiter;
    localparam int DC = 3;
    logic       clk = 1'b0;
    logic       reset, entry_req, exit_req, car_passed;
    logic [1:0] exit_pos;
    logic       gate_open, entry_grant, exit_grant, full_led, err_invalid_exit, timeout;
    logic [1:0] assigned_pos;
    logic [3:0] parking_spots;
    logic [2:0] capacity;
    parking_gate_arbiter #(.DOOR_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
        .exit_pos(exit_pos), .car_passed(car_passed), .gate_open(gate_open),
        .entry_grant(entry_grant), .exit_grant(exit_grant), .assigned_pos(assigned_pos),
        .parking_spots(parking_spots), .capacity(capacity), .full_led(full_led),
        .err_invalid_exit(err_invalid_exit), .timeout(timeout)
    );
    always #5 clk = ~clk;
    int n_cmp = 0;
    int n_bad = 0;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask
    // model: which car is being served (none/entry/exit/closing) and how long the gate has been open
    int  occ[4];
    int  phase;
    int  opened, apos, xpos;
    bit  pref_exit, eg, xg;
    function automatic int free_cnt();
        int f = 4;
        for (int i = 0; i < 4; i++) f -= occ[i];
        return f;
    endfunction
    function automatic logic [3:0] bitmap();
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = occ[i] != 0;
        return b;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 4; i++) occ[i] = 0;
        phase = 0; opened = 0; apos = 0; xpos = 0;
        pref_exit = 1'b1; eg = 1'b0; xg = 1'b0;
    endtask
    task automatic check_all();
        bit is_open = phase == 1 || phase == 2;
        check("gate_open", 8'(gate_open), 8'(is_open));
        check("entry_grant", 8'(entry_grant), 8'(eg));
        check("exit_grant", 8'(exit_grant), 8'(xg));
        check("assigned_pos", 8'(assigned_pos), 8'(apos));
        check("parking_spots", 8'(parking_spots), 8'(bitmap()));
        check("capacity", 8'(capacity), 8'(free_cnt()));
        check("full_led", 8'(full_led), 8'(free_cnt() == 0));
        check("err_invalid_exit", 8'(err_invalid_exit), 8'(phase == 0 && exit_req && occ[exit_pos] == 0));
        check("timeout", 8'(timeout), 8'(is_open && !car_passed && opened == DC));
    endtask
    task automatic model_step();
        bit ev, xv;
        eg = 1'b0;
        xg = 1'b0;
        if (phase == 0) begin
            ev = entry_req && free_cnt() > 0;
            xv = exit_req && occ[exit_pos] != 0;
            if (xv && (!ev || pref_exit)) begin
                phase = 2; xpos = exit_pos; xg = 1'b1; pref_exit = 1'b0; opened = 1;
            end else if (ev) begin
                phase = 1; eg = 1'b1; pref_exit = 1'b1; opened = 1;
                for (int i = 3; i >= 0; i--) if (occ[i] == 0) apos = i;
            end
        end else if (phase == 1 || phase == 2) begin
            if (car_passed) begin
                if (phase == 1) occ[apos] = 1;
                else occ[xpos] = 0;
                phase = 3;
            end else if (opened == DC) begin
                phase = 3;
            end else begin
                opened++;
            end
        end else begin
            phase = 0;
        end
    endtask
    initial begin
        reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_pos = 2'd0; car_passed = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            reset      = $urandom_range(0, 249) == 0;
            entry_req  = $urandom_range(0, 9) < 7;
            exit_req   = $urandom_range(0, 9) < 5;
            exit_pos   = 2'($urandom_range(0, 3));
            car_passed = $urandom_range(0, 2) == 0;
            if (reset) model_reset();
            #1;
            check_all();
            @(posedge clk);
            if (!reset) model_step();
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
